// File: rtl/rib_timer.sv
// rib_timer: prescaled 32-bit timer on a RIB slave port.
// Compare match, one-shot/periodic modes, level interrupt.
module rib_timer #(
  parameter int          PRESC_W = 16,
  parameter logic [31:0] RST_CMP = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic        int_sig_o
);

  logic               en;
  logic               int_en;
  logic               pend;
  logic               periodic;
  logic [31:0]        count;
  logic [31:0]        cmp;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;

  logic mapped;
  logic sel_ctrl;
  logic sel_count;
  logic sel_cmp;
  logic sel_presc;
  logic wr_ctrl;
  logic wr_count;
  logic wr_cmp;
  logic wr_presc;
  logic tick;
  logic hit;
  logic en_chg;
  logic unused_addr;

  assign unused_addr = ^{addr_i[31:28], addr_i[1:0]};

  assign mapped    = (addr_i[27:8] == 20'd0);
  assign sel_ctrl  = mapped && (addr_i[7:2] == 6'd0);
  assign sel_count = mapped && (addr_i[7:2] == 6'd1);
  assign sel_cmp   = mapped && (addr_i[7:2] == 6'd2);
  assign sel_presc = mapped && (addr_i[7:2] == 6'd3);

  assign wr_ctrl  = we_i && sel_ctrl;
  assign wr_count = we_i && sel_count;
  assign wr_cmp   = we_i && sel_cmp;
  assign wr_presc = we_i && sel_presc;

  assign tick   = en && (pcnt == presc);
  assign hit    = tick && (count == cmp);
  assign en_chg = wr_ctrl && (data_i[0] != en);

  always_comb begin
    data_o = 32'd0;
    unique case (1'b1)
      sel_ctrl:  data_o = {28'd0, periodic, pend, int_en, en};
      sel_count: data_o = count;
      sel_cmp:   data_o = cmp;
      sel_presc: data_o = {{(32-PRESC_W){1'b0}}, presc};
      default:   data_o = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en        <= 1'b0;
      int_en    <= 1'b0;
      pend      <= 1'b0;
      periodic  <= 1'b0;
      count     <= 32'd0;
      cmp       <= RST_CMP;
      presc     <= '0;
      pcnt      <= '0;
      int_sig_o <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en       <= data_i[0];
        int_en   <= data_i[1];
        periodic <= data_i[3];
      end
      // one-shot auto-clear overrides a same-cycle EN write
      if (hit && !periodic)
        en <= 1'b0;

      if (hit)
        pend <= 1'b1;
      else if (wr_ctrl && data_i[2])
        pend <= 1'b0;

      if (wr_count)
        count <= data_i;
      else if (tick)
        count <= hit ? 32'd0 : count + 32'd1;

      if (wr_cmp)
        cmp <= data_i;
      if (wr_presc)
        presc <= data_i[PRESC_W-1:0];

      if (wr_presc || en_chg || !en || tick)
        pcnt <= '0;
      else
        pcnt <= pcnt + 1'b1;

      int_sig_o <= pend & int_en;
    end
  end

endmodule

// File: tb/tb_rib_timer.sv
// tb_rib_timer: directed + random checks of rib_timer
// against a cycle-level register model.
module tb_rib_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] data_o;
  logic        int_sig_o;

  always #5 clk = ~clk;

  rib_timer dut (
    .clk       (clk),
    .rst       (rst),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .we_i      (we_i),
    .data_o    (data_o),
    .int_sig_o (int_sig_o)
  );

  int tests = 0;
  int fails = 0;

  bit          m_valid = 0;
  bit          m_en, m_ie, m_pend, m_per, m_int;
  logic [31:0] m_count, m_cmp;
  logic [15:0] m_presc, m_pcnt;

  task automatic expect32(input string name,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[27:8] != 0) return 32'd0;
    case (a[7:2])
      6'd0: return {28'd0, m_per, m_pend, m_ie, m_en};
      6'd1: return m_count;
      6'd2: return m_cmp;
      6'd3: return {16'd0, m_presc};
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock using this cycle's bus inputs.
  task automatic m_step(input bit r, input logic [31:0] a,
                        input logic [31:0] d, input bit w);
    bit tick, hit, n_en, n_pend;
    logic [31:0] n_count;
    logic [15:0] n_pcnt;
    int reg_idx;
    if (!r) begin
      {m_en, m_ie, m_pend, m_per, m_int} = '0;
      m_count = 0;
      m_cmp = 32'hFFFF_FFFF;
      m_presc = 0;
      m_pcnt = 0;
      m_valid = 1;
      return;
    end
    reg_idx = (a[27:8] == 0 && a[7:2] < 4) ? int'(a[7:2]) : -1;
    if (!w) reg_idx = -1;
    tick = m_en && (m_pcnt == m_presc);
    hit = tick && (m_count == m_cmp);
    m_int = m_pend & m_ie;
    n_en = m_en;
    n_pend = m_pend;
    n_count = tick ? (hit ? 32'd0 : m_count + 1) : m_count;
    n_pcnt = (tick || !m_en) ? 16'd0 : m_pcnt + 1;
    if (reg_idx == 0) begin
      if (d[0] != m_en) n_pcnt = 0;
      n_en = d[0];
      m_ie = d[1];
      if (d[2]) n_pend = 0;
    end
    if (hit) begin
      n_pend = 1;
      if (!m_per) n_en = 0;
    end
    if (reg_idx == 0) m_per = d[3];
    if (reg_idx == 1) n_count = d;
    if (reg_idx == 2) m_cmp = d;
    if (reg_idx == 3) begin
      m_presc = d[15:0];
      n_pcnt = 0;
    end
    m_en = n_en;
    m_pend = n_pend;
    m_count = n_count;
    m_pcnt = n_pcnt;
  endtask

  // One bus cycle: drive at negedge, compare outputs, step at posedge.
  task automatic cyc(input bit r, input logic [31:0] a,
                     input logic [31:0] d, input bit w,
                     output logic [31:0] rdv, output logic irq);
    @(negedge clk);
    rst = r;
    addr_i = a;
    data_i = d;
    we_i = w;
    #1;
    rdv = data_o;
    irq = int_sig_o;
    if (m_valid) begin
      expect32("model_data_o", rdv, m_read(a));
      expect32("model_int", {31'd0, irq}, {31'd0, m_int});
    end
    @(posedge clk);
    m_step(r, a, d, w);
  endtask

  logic [31:0] rv;
  logic        iq;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1, a, d, 1, rv, iq);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1, a, 32'd0, 0, rv, iq);
  endtask

  task automatic do_reset();
    cyc(0, 32'd0, 32'd0, 0, rv, iq);
  endtask

  initial begin
    logic [31:0] a, d;
    bit w, r;

    // reset values
    do_reset();
    do_reset();
    rd(32'h0);  expect32("rst_ctrl", rv, 32'h0);
    rd(32'h4);  expect32("rst_count", rv, 32'h0);
    rd(32'h8);  expect32("rst_cmp", rv, 32'hFFFF_FFFF);
    rd(32'hC);  expect32("rst_presc", rv, 32'h0);
    expect32("rst_int", {31'd0, iq}, 32'd0);

    // periodic, no prescale
    do_reset();
    wr(32'hC, 0);
    wr(32'h8, 3);
    wr(32'h0, 32'hB);
    for (int k = 0; k < 10; k++) begin
      rd(32'h4);
      expect32("per_count", rv, k % 4);
      expect32("per_int", {31'd0, iq}, (k >= 5) ? 32'd1 : 32'd0);
    end
    wr(32'h0, 32'hF);
    rd(32'h0);  expect32("per_w1c", rv, 32'hB);

    // one-shot with prescaler 2
    do_reset();
    wr(32'hC, 2);
    wr(32'h8, 1);
    wr(32'h0, 32'h3);
    for (int k = 0; k < 6; k++) begin
      rd(32'h4);
      expect32("os_count", rv, (k >= 3) ? 32'd1 : 32'd0);
    end
    rd(32'h0);  expect32("os_ctrl", rv, 32'h6);
    for (int k = 0; k < 20; k++) begin
      rd(32'h4);
      expect32("os_frozen", rv, 32'd0);
    end
    expect32("os_int", {31'd0, iq}, 32'd1);

    // collisions
    do_reset();
    wr(32'hC, 0);
    wr(32'h8, 3);
    wr(32'h0, 32'hB);
    for (int k = 0; k < 3; k++) rd(32'h4);
    wr(32'h0, 32'hF);
    rd(32'h0);  expect32("col_pend", rv, 32'hF);
    wr(32'h4, 32'h10);
    rd(32'h4);  expect32("col_cnt_wr", rv, 32'h10);
    rd(32'h4);  expect32("col_cnt_inc", rv, 32'h11);

    // wrap and unmapped
    do_reset();
    wr(32'h8, 5);
    wr(32'h4, 32'hFFFF_FFFF);
    wr(32'h0, 32'h9);
    rd(32'h4);  expect32("wrap_pre", rv, 32'hFFFF_FFFF);
    rd(32'h0);  expect32("wrap_nopend", rv, 32'h9);
    wr(32'h0, 0);
    wr(32'h10, 32'h1234);
    wr(32'h104, 32'h1234);
    rd(32'h10);  expect32("unm_10", rv, 32'h0);
    rd(32'h104); expect32("unm_104", rv, 32'h0);
    rd(32'h4);   expect32("unm_count", rv, 32'h2);
    rd(32'h8);   expect32("unm_cmp", rv, 32'h5);
    rd(32'hC);   expect32("unm_presc", rv, 32'h0);

    // mid-run reset
    do_reset();
    wr(32'h8, 1);
    wr(32'h0, 32'hB);
    for (int k = 0; k < 6; k++) rd(32'h0);
    expect32("mid_int_hi", {31'd0, iq}, 32'd1);
    do_reset();
    rd(32'h0);  expect32("mid_ctrl", rv, 32'h0);
    expect32("mid_int", {31'd0, iq}, 32'd0);
    rd(32'h8);  expect32("mid_cmp", rv, 32'hFFFF_FFFF);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      r = ($urandom_range(0, 299) != 0);
      w = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2: a = 32'h0;
        3, 4:    a = 32'h4;
        5:       a = 32'h8;
        6:       a = 32'hC;
        7:       a = 32'h10 + ($urandom_range(0, 60) << 2);
        8:       a = 32'h104;
        default: a = $urandom & 32'h0FFF_FFFF;
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      case (a[7:2])
        6'd0: d = ($urandom_range(0, 7) == 0) ? $urandom
                                              : 32'($urandom_range(0, 15));
        6'd1: d = ($urandom_range(0, 5) == 0)
                    ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                    : 32'($urandom_range(0, 12));
        6'd2: d = 32'($urandom_range(0, 10));
        6'd3: d = 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      cyc(r, a, d, w, rv, iq);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
